sum_vector_generator: RTL and testbench
=======================================

# sum_vector_generator

- Operand-side front end for the 7-bit conditional-sum adder.
- Accepts two operands over a valid/ready handshake and computes, with a bit-serial carry chain, two candidate sets of vectors:
  - the carry-in-0 set: `half_sum_vector`, `carry_generate_vector`;
  - the carry-in-1 set: `h_prim`, `g_prim`.
- Presents both sets, registered and held, to the downstream sum computation stage under a second valid/ready handshake.

## Interface
- `WIDTH`, 7: operand and vector width; must be ≥2. Index `WIDTH-1` is the least-significant bit and index 0 the most-significant bit.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `a_in` in WIDTH: operand A.
- `b_in` in WIDTH: operand B.
- `in_valid` in 1: operands valid.
- `in_ready` out 1: block can accept operands.
- `half_sum_vector` out WIDTH: A^B.
- `h_prim` out WIDTH: half-sum vector for carry-in = 1.
- `carry_generate_vector` out WIDTH: per-bit carry-out, carry-in = 0.
- `g_prim` out WIDTH: per-bit carry-out, carry-in = 1.
- `out_valid` out 1: output vectors valid.
- `out_ready` in 1: downstream accepts the vectors.
- `busy` out 1: high when state is RIPPLE.

## Operation
- Per-bit terms:
  - p[i] = a[i]^b[i]
  - g[i] = a[i]&b[i]
- Output vector definitions:
  - `half_sum_vector` = p.
  - `h_prim` = p with bit WIDTH-1 inverted.
  - `carry_generate_vector`[i] = g[i] | (p[i] & c0[i+1]), where the carry into bit WIDTH-1 is 0.
  - `g_prim` is the same recurrence, with the carry into bit WIDTH-1 equal to 1.
- State machine:
  - IDLE:
    - `in_ready`=1.
    - On `in_valid`&`in_ready`: latch `a_in`/`b_in` into work registers, set bit counter `cnt`=WIDTH-1, clear both running carries to 0/1, go to RIPPLE.
  - RIPPLE:
    - Each cycle, compute the carry-out at bit `cnt` for both chains, write it into the work carry registers, and update both running carries.
    - If `cnt`==0: copy all four work vectors into the output registers, set `out_valid`=1, go to DONE.
    - Otherwise decrement `cnt`.
  - DONE:
    - Output registers and `out_valid` are held.
    - On `out_valid`&`out_ready`: clear `out_valid`, go to IDLE.
- Output registers change only on the RIPPLE→DONE transition. Between results they retain the last result.
- `in_valid` outside IDLE is ignored; operands are not queued.
- Arithmetic is unsigned and has no overflow output. Carry-out of bit 0 appears only as bit 0 of the carry vectors.

## Timing
- Reset values:
  - state IDLE, `in_ready`=1, `out_valid`=0, `busy`=0;
  - all four vectors 0, `cnt`=0, work registers 0.
- Reset asserted in any state aborts immediately. No `out_valid` pulse is produced for the aborted operation.
- Latency: with the input handshake at edge E0, `out_valid` rises after edge E(WIDTH), i.e. edge E7 by default. `busy`=1 from after E0 through E(WIDTH).
- `in_ready` is combinational from state (IDLE only). The earliest next input handshake is the edge after the output handshake, so back-to-back throughput is one result per WIDTH+2 cycles.
- `out_valid`&`out_ready` in the same cycle as `in_valid` completes the output only; the input is taken in a later IDLE cycle.
- Downstream stall of any length keeps all outputs bit-stable.

## Configuration
- `SUMGEN_ONECYCLE_EN`:
  - Defined: RIPPLE is replaced by a single cycle that evaluates both full carry chains combinationally. `out_valid` rises after edge E1, `busy` is high for one cycle, and `cnt` is not used.
  - Undefined: bit-serial operation as above.
  - Output values are identical in both builds.

## Test plan
- a=7'b0000011, b=7'b0000001:
  - after 7 cycles, `out_valid`=1;
  - `half_sum_vector`=7'b0000010, `h_prim`=7'b0000011, `carry_generate_vector`=7'b0000011, `g_prim`=7'b0000011.
- a=7'b1111111, b=7'b0000000 -> `half_sum_vector`=7'b1111111, `h_prim`=7'b1111110, `carry_generate_vector`=7'b0000000, `g_prim`=7'b1111111.
- a=b=7'b1111111 -> `half_sum_vector`=7'b0000000, `h_prim`=7'b0000001, `carry_generate_vector`=7'b1111111, `g_prim`=7'b1111111.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE while pulsing `in_valid` with new operands:
  - outputs unchanged, `in_ready`=0, new operands dropped;
  - after `out_ready`=1, `out_valid`=0 and `in_ready`=1 one cycle later.
- Reset mid-RIPPLE: assert `rst` 3 cycles after the input handshake:
  - all vectors 0, `out_valid`=0, `in_ready`=1;
  - `out_valid` never rises for that operand.
- Build with `SUMGEN_ONECYCLE_EN` and rerun the first three scenarios: identical vectors, `out_valid` rises one cycle after the input handshake.

Source files
------------

// File: rtl/sum_vector_generator.sv
// sum_vector_generator: operand front end of the conditional-sum adder; builds the carry-in 0/1 vector sets.
// Define SUMGEN_ONECYCLE_EN to evaluate both carry chains in a single cycle instead of bit-serially.
`default_nettype none

module sum_vector_generator #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [0:WIDTH-1] a_in,
    input  logic [0:WIDTH-1] b_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [0:WIDTH-1] half_sum_vector,
    output logic [0:WIDTH-1] h_prim,
    output logic [0:WIDTH-1] carry_generate_vector,
    output logic [0:WIDTH-1] g_prim,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RIPPLE = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]       state;
    logic [0:WIDTH-1] a_work;
    logic [0:WIDTH-1] b_work;
    logic [0:WIDTH-1] p_work;
    logic [0:WIDTH-1] hp_work;
    logic [0:WIDTH-1] cg_result;
    logic [0:WIDTH-1] gp_result;
    logic             accept;
    logic             finish;

    assign in_ready = (state == IDLE);
    assign busy     = (state == RIPPLE);
    assign accept   = in_valid & in_ready;

    // Index WIDTH-1 is the LSB, so the carry-in-1 half sum flips the rightmost bit.
    assign p_work  = a_work ^ b_work;
    assign hp_work = p_work ^ {{(WIDTH-1){1'b0}}, 1'b1};

`ifdef SUMGEN_ONECYCLE_EN
    logic chain0;
    logic chain1;

    always_comb begin
        chain0    = 1'b0;
        chain1    = 1'b1;
        cg_result = '0;
        gp_result = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            cg_result[i] = (a_work[i] & b_work[i]) | (p_work[i] & chain0);
            gp_result[i] = (a_work[i] & b_work[i]) | (p_work[i] & chain1);
            chain0       = cg_result[i];
            chain1       = gp_result[i];
        end
    end

    assign finish = (state == RIPPLE);
`else
    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [CW-1:0]    cnt;
    logic             carry0;
    logic             carry1;
    logic [0:WIDTH-1] cg_work;
    logic [0:WIDTH-1] gp_work;
    logic             bit_p;
    logic             bit_g;
    logic             bit_c0;
    logic             bit_c1;

    assign bit_p  = a_work[cnt] ^ b_work[cnt];
    assign bit_g  = a_work[cnt] & b_work[cnt];
    assign bit_c0 = bit_g | (bit_p & carry0);
    assign bit_c1 = bit_g | (bit_p & carry1);

    // Work vectors with the current bit merged in, so the final bit reaches the outputs on the same edge.
    always_comb begin
        cg_result = cg_work;
        gp_result = gp_work;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt == CW'(i)) begin
                cg_result[i] = bit_c0;
                gp_result[i] = bit_c1;
            end
        end
    end

    assign finish = (state == RIPPLE) && (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            carry0  <= 1'b0;
            carry1  <= 1'b0;
            cg_work <= '0;
            gp_work <= '0;
        end else if (accept) begin
            cnt     <= LAST;
            carry0  <= 1'b0;
            carry1  <= 1'b1;
            cg_work <= '0;
            gp_work <= '0;
        end else if (state == RIPPLE) begin
            cg_work <= cg_result;
            gp_work <= gp_result;
            carry0  <= bit_c0;
            carry1  <= bit_c1;
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                 <= IDLE;
            a_work                <= '0;
            b_work                <= '0;
            half_sum_vector       <= '0;
            h_prim                <= '0;
            carry_generate_vector <= '0;
            g_prim                <= '0;
            out_valid             <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_work <= a_in;
                        b_work <= b_in;
                        state  <= RIPPLE;
                    end
                end
                RIPPLE: begin
                    if (finish) begin
                        half_sum_vector       <= p_work;
                        h_prim                <= hp_work;
                        carry_generate_vector <= cg_result;
                        g_prim                <= gp_result;
                        out_valid             <= 1'b1;
                        state                 <= DONE;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sum_vector_generator.sv
// Directed, table-driven self-checking bench for sum_vector_generator.
`default_nettype none

module tb_sum_vector_generator;

    localparam int WIDTH = 7;
`ifdef SUMGEN_ONECYCLE_EN
    localparam int LAT = 1;
`else
    localparam int LAT = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [0:WIDTH-1] a_in = '0;
    logic [0:WIDTH-1] b_in = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [0:WIDTH-1] half_sum_vector;
    logic [0:WIDTH-1] h_prim;
    logic [0:WIDTH-1] carry_generate_vector;
    logic [0:WIDTH-1] g_prim;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sum_vector_generator #(.WIDTH(WIDTH)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .a_in                 (a_in),
        .b_in                 (b_in),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .half_sum_vector      (half_sum_vector),
        .h_prim               (h_prim),
        .carry_generate_vector(carry_generate_vector),
        .g_prim               (g_prim),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .busy                 (busy)
    );

    typedef struct {
        logic [6:0] a;
        logic [6:0] b;
        logic [6:0] hsv;
        logic [6:0] hp;
        logic [6:0] cg;
        logic [6:0] gp;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act[WIDTH-1:0], exp[WIDTH-1:0]);
        end
    endtask

    task automatic chk_vecs(input string tag, input vec_t v);
        chk({tag, " half_sum_vector"}, 32'(half_sum_vector), 32'(v.hsv));
        chk({tag, " h_prim"}, 32'(h_prim), 32'(v.hp));
        chk({tag, " carry_generate_vector"}, 32'(carry_generate_vector), 32'(v.cg));
        chk({tag, " g_prim"}, 32'(g_prim), 32'(v.gp));
    endtask

    // Input handshake, then wait for out_valid; leaves the block in DONE with out_ready low.
    task automatic start_op(input string tag, input logic [6:0] a, input logic [6:0] b);
        int lat;
        @(negedge clk);
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        chk({tag, " in_ready before handshake"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, " busy after handshake"}, 32'(busy), 32'd1);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(LAT));
    endtask

    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " out_valid after release"}, 32'(out_valid), 32'd0);
        chk({tag, " in_ready after release"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        vec_t bp;
        int   seen;

        vecs[0] = '{7'b0000011, 7'b0000001, 7'b0000010, 7'b0000011, 7'b0000011, 7'b0000011};
        vecs[1] = '{7'b1111111, 7'b0000000, 7'b1111111, 7'b1111110, 7'b0000000, 7'b1111111};
        vecs[2] = '{7'b1111111, 7'b1111111, 7'b0000000, 7'b0000001, 7'b1111111, 7'b1111111};
        vecs[3] = '{7'b0000101, 7'b0000011, 7'b0000110, 7'b0000111, 7'b0000111, 7'b0000111};
        vecs[4] = '{7'b1010101, 7'b0101010, 7'b1111111, 7'b1111110, 7'b0000000, 7'b1111111};
        vecs[5] = '{7'b1000000, 7'b1000000, 7'b0000000, 7'b0000001, 7'b1000000, 7'b1000000};

        // Reset state
        @(negedge clk);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset hsv", 32'(half_sum_vector), 32'd0);
        chk("reset h_prim", 32'(h_prim), 32'd0);
        chk("reset cg", 32'(carry_generate_vector), 32'd0);
        chk("reset g_prim", 32'(g_prim), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            start_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b);
            chk_vecs($sformatf("vec%0d", i), vecs[i]);
            finish_op($sformatf("vec%0d", i));
        end

        // Backpressure: downstream stalls while new operands are offered
        bp = vecs[0];
        start_op("bp", bp.a, bp.b);
        for (int k = 0; k < 5; k++) begin
            a_in     = 7'(k + 40);
            b_in     = 7'(k * 3 + 1);
            in_valid = 1'b1;
            @(negedge clk);
            chk("bp in_ready held low", 32'(in_ready), 32'd0);
            chk("bp out_valid held", 32'(out_valid), 32'd1);
            chk_vecs("bp stall", bp);
        end
        in_valid = 1'b0;
        finish_op("bp");
        @(negedge clk);
        chk("bp operands dropped busy", 32'(busy), 32'd0);
        chk("bp operands dropped out_valid", 32'(out_valid), 32'd0);
        chk_vecs("bp retained", bp);

        // Reset mid-ripple: aborts with no result
        @(negedge clk);
        a_in     = 7'b0110110;
        b_in     = 7'b0011011;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst hsv", 32'(half_sum_vector), 32'd0);
        chk("rst h_prim", 32'(h_prim), 32'd0);
        chk("rst cg", 32'(carry_generate_vector), 32'd0);
        chk("rst g_prim", 32'(g_prim), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("rst no out_valid pulse", 32'(seen), 32'd0);

        // Block still operational after the abort
        start_op("post_rst", vecs[3].a, vecs[3].b);
        chk_vecs("post_rst", vecs[3]);
        finish_op("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
